// File: rtl/gpio_uart_host_if.sv
// Byte-stream handshake and GPIO pin bundle between gpio_uart_host and its neighbours.
// The slave modport is the gpio_uart_host side; master is the host/bench side.
interface gpio_uart_host_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;
  logic [7:0] gpio_pin_in;
  logic [7:0] gpio_pin_out;

  modport slave (
    input  tx_data, tx_valid, rx_ready, gpio_pin_out,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, gpio_pin_in
  );

  modport master (
    output tx_data, tx_valid, rx_ready, gpio_pin_out,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, gpio_pin_in
  );
endinterface

// File: rtl/gpio_uart_host.sv
// Host-side 8N1 UART peer for the HSM GPIO link; serial data on bit 0 of each GPIO bus.
// Define GPIO_UART_HOST_PARITY_EN to insert/check an even-parity bit (11-bit frames).
//
// state       | meaning
// S_IDLE      | line idle; TX accepts a byte, RX waits for a synchronized 0
// S_START     | start bit (TX full bit, RX half bit then re-sample)
// S_DATA      | 8 data bits, LSB first
// S_PARITY    | even-parity bit (parity build only)
// S_STOP      | stop bit; RX decides deliver / overrun / error at its centre
// S_WAIT_IDLE | RX only: after a framing error, wait for the line to return to 1
module gpio_uart_host #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  gpio_uart_host_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;

  state_t        r_tx_state, w_tx_state;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt;
  logic [2:0]    r_tx_bit, w_tx_bit;
  logic [7:0]    r_tx_sh, w_tx_sh;
  logic          r_tx_line, w_tx_line;
  logic          w_tx_tc;

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_sh    = r_tx_sh;
    w_tx_line  = r_tx_line;
    w_tx_tc    = (r_tx_cnt == '0);
    case (r_tx_state)
      S_IDLE: begin
        w_tx_line = 1'b1;
        if (bus.tx_valid) begin
          w_tx_state = S_START;
          w_tx_line  = 1'b0;
          w_tx_cnt   = C_FULL;
          w_tx_sh    = bus.tx_data;
        end
      end
      S_START: begin
        if (w_tx_tc) begin
          w_tx_state = S_DATA;
          w_tx_bit   = 3'd0;
          w_tx_line  = r_tx_sh[0];
          w_tx_cnt   = C_FULL;
        end else w_tx_cnt = r_tx_cnt - C_ONE;
      end
      S_DATA: begin
        if (w_tx_tc) begin
          w_tx_cnt = C_FULL;
          if (r_tx_bit == 3'd7) begin
`ifdef GPIO_UART_HOST_PARITY_EN
            w_tx_state = S_PARITY;
            w_tx_line  = ^r_tx_sh;
`else
            w_tx_state = S_STOP;
            w_tx_line  = 1'b1;
`endif
          end else begin
            w_tx_bit  = r_tx_bit + 3'd1;
            w_tx_line = r_tx_sh[w_tx_bit];
          end
        end else w_tx_cnt = r_tx_cnt - C_ONE;
      end
      S_PARITY: begin
        if (w_tx_tc) begin
          w_tx_state = S_STOP;
          w_tx_line  = 1'b1;
          w_tx_cnt   = C_FULL;
        end else w_tx_cnt = r_tx_cnt - C_ONE;
      end
      S_STOP: begin
        w_tx_line = 1'b1;
        if (w_tx_tc) w_tx_state = S_IDLE;
        else         w_tx_cnt   = r_tx_cnt - C_ONE;
      end
      default: begin
        w_tx_state = S_IDLE;
        w_tx_line  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_sh    <= 8'h00;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_sh    <= w_tx_sh;
      r_tx_line  <= w_tx_line;
    end
  end

  assign bus.tx_ready    = (r_tx_state == S_IDLE);
  assign bus.gpio_pin_in = {7'b0, r_tx_line};

  logic          r_sync1, r_sync2;
  state_t        r_rx_state, w_rx_state;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt;
  logic [2:0]    r_rx_bit, w_rx_bit;
  logic [7:0]    r_rx_sh, w_rx_sh;
  logic [7:0]    r_rx_data, w_rx_data;
  logic          r_rx_valid, w_rx_valid;
  logic          r_rx_ferr, w_rx_ferr;
  logic          r_rx_ovr, w_rx_ovr;
  logic          w_rx_in, w_rx_tc;
  logic          w_unused_pins;
`ifdef GPIO_UART_HOST_PARITY_EN
  logic          r_rx_par_bad, w_rx_par_bad;
  logic          r_rx_perr, w_rx_perr;
`endif

  assign w_unused_pins = ^bus.gpio_pin_out[7:1];

  always_comb begin
    w_rx_in    = r_sync2;
    w_rx_tc    = (r_rx_cnt == '0);
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_sh    = r_rx_sh;
    w_rx_data  = r_rx_data;
    w_rx_valid = r_rx_valid & ~bus.rx_ready;
    w_rx_ferr  = 1'b0;
    w_rx_ovr   = 1'b0;
`ifdef GPIO_UART_HOST_PARITY_EN
    w_rx_par_bad = r_rx_par_bad;
    w_rx_perr    = 1'b0;
`endif
    case (r_rx_state)
      S_IDLE: begin
        if (!w_rx_in) begin
          w_rx_state = S_START;
          w_rx_cnt   = C_HALF;
        end
      end
      S_START: begin
        if (w_rx_tc) begin
          w_rx_state = w_rx_in ? S_IDLE : S_DATA;
          w_rx_bit   = 3'd0;
          w_rx_cnt   = C_FULL;
        end else w_rx_cnt = r_rx_cnt - C_ONE;
      end
      S_DATA: begin
        if (w_rx_tc) begin
          w_rx_sh  = {w_rx_in, r_rx_sh[7:1]};
          w_rx_cnt = C_FULL;
          if (r_rx_bit == 3'd7) begin
`ifdef GPIO_UART_HOST_PARITY_EN
            w_rx_state = S_PARITY;
`else
            w_rx_state = S_STOP;
`endif
          end else w_rx_bit = r_rx_bit + 3'd1;
        end else w_rx_cnt = r_rx_cnt - C_ONE;
      end
      S_PARITY: begin
        if (w_rx_tc) begin
`ifdef GPIO_UART_HOST_PARITY_EN
          w_rx_par_bad = w_rx_in ^ (^r_rx_sh);
`endif
          w_rx_state = S_STOP;
          w_rx_cnt   = C_FULL;
        end else w_rx_cnt = r_rx_cnt - C_ONE;
      end
      S_STOP: begin
        if (w_rx_tc) begin
          if (!w_rx_in) begin
            w_rx_ferr  = 1'b1;
            w_rx_state = S_WAIT_IDLE;
          end else begin
            w_rx_state = S_IDLE;
`ifdef GPIO_UART_HOST_PARITY_EN
            if (r_rx_par_bad) w_rx_perr = 1'b1;
            else
`endif
            // A consume on this same edge frees the holding register, so no overrun.
            if (r_rx_valid && !bus.rx_ready) w_rx_ovr = 1'b1;
            else begin
              w_rx_data  = r_rx_sh;
              w_rx_valid = 1'b1;
            end
          end
        end else w_rx_cnt = r_rx_cnt - C_ONE;
      end
      S_WAIT_IDLE: begin
        if (w_rx_in) w_rx_state = S_IDLE;
      end
      default: w_rx_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_sh    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
`ifdef GPIO_UART_HOST_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_rx_perr    <= 1'b0;
`endif
    end else begin
      r_sync1    <= bus.gpio_pin_out[0];
      r_sync2    <= r_sync1;
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_sh    <= w_rx_sh;
      r_rx_data  <= w_rx_data;
      r_rx_valid <= w_rx_valid;
      r_rx_ferr  <= w_rx_ferr;
      r_rx_ovr   <= w_rx_ovr;
`ifdef GPIO_UART_HOST_PARITY_EN
      r_rx_par_bad <= w_rx_par_bad;
      r_rx_perr    <= w_rx_perr;
`endif
    end
  end

  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_frame_err = r_rx_ferr;
  assign bus.rx_overrun   = r_rx_ovr;
`ifdef GPIO_UART_HOST_PARITY_EN
  assign bus.rx_parity_err = r_rx_perr;
`else
  assign bus.rx_parity_err = 1'b0;
`endif
endmodule

// File: doc/gpio_uart_host.md
# gpio_uart_host

Host-side peer for the HSM's GPIO serial link. It sits in the bench or host fabric opposite `hsm`: it drives the HSM's `gpio_pin_in` and observes its `gpio_pin_out`. It converts byte-wide valid/ready streams to and from 8N1 asynchronous serial frames on bit 0 of each GPIO bus. This lets the firmware's bit-banged UART be exercised and driven cycle-accurately.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 4, even values only.
- `clk`  in  1: single clock; all state is on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset; deassertion is synchronous to `clk` by the instantiating system.
- `tx_data`  in  8: byte to send.
- `tx_valid`  in  1: `tx_data` is offered.
- `tx_ready`  out  1: transmitter can accept a byte.
- `rx_data`  out  8: last received byte.
- `rx_valid`  out  1: `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1: consumer takes `rx_data`.
- `rx_frame_err`  out  1: one-cycle pulse; stop bit sampled low.
- `rx_parity_err`  out  1: one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.
- `rx_overrun`  out  1: one-cycle pulse; a good byte completed while `rx_valid` was high.
- `gpio_pin_in`  out  8: to the HSM. Bit 0 carries serial TX data; bits 7:1 are constant 0.
- `gpio_pin_out`  in  8: from the HSM. Bit 0 carries serial RX data; bits 7:1 are ignored.

## Operation
- Frame format: start bit (0), data bits LSB first, optional parity bit, stop bit (1). The line idles at 1.
- TX state machine: IDLE → START → DATA(8) → [PARITY] → STOP → IDLE.
  - In IDLE, `tx_ready`=1. A transfer occurs when `tx_valid && tx_ready` on a clock edge; that edge latches `tx_data` into the shift register.
  - Each state lasts exactly `CLKS_PER_BIT` cycles, and `gpio_pin_in[0]` is registered.
  - `tx_data` changes after acceptance do not affect the frame in flight.
- RX input: `gpio_pin_out[0]` passes through a 2-flop synchronizer. Bit decisions use only the synchronized value.
- RX state machine: IDLE → START → DATA(8) → [PARITY] → STOP → IDLE, plus WAIT_IDLE.
  - IDLE: a synchronized 0 enters START.
  - START: after `CLKS_PER_BIT/2` cycles, re-sample. If the line is 1, the start was false and the machine returns to IDLE silently. If 0, it proceeds.
  - DATA, PARITY, STOP: each is sampled at its bit centre, `CLKS_PER_BIT` cycles after the previous sample.
  - Stop = 1 with no parity error:
    - If `rx_valid`=0, load `rx_data` and set `rx_valid`.
    - If `rx_valid`=1, pulse `rx_overrun`, drop the new byte and keep the old one.
  - Stop = 1 with a parity error: pulse `rx_parity_err` and drop the byte.
  - Stop = 0: pulse `rx_frame_err`, drop the byte, and go to WAIT_IDLE, which returns to IDLE on the first synchronized 1.
- RX handshake: `rx_valid` clears on an edge with `rx_valid && rx_ready`.
  - If a byte completes on that same edge, the new byte is loaded, `rx_valid` stays 1, and no overrun is flagged.
- TX and RX are fully independent; simultaneous activity is legal.

## Timing
- Reset values (asynchronous): `gpio_pin_in`=8'h01, `tx_ready`=1, `rx_valid`=0, `rx_data`=8'h00, all error pulses 0, both FSMs in IDLE, synchronizer flops = 1.
- Reset asserted mid-frame aborts both directions immediately; the TX line returns to idle 1 asynchronously.
- TX latency: start bit appears on `gpio_pin_in[0]` in the cycle after the accepting edge.
- TX frame length: 10·`CLKS_PER_BIT` cycles (11· with parity).
- `tx_ready` falls on the accepting edge and rises in the cycle after the final stop-bit cycle. Accepting a byte on that cycle gives back-to-back frames with no extra idle bits.
- RX latency: `rx_valid` rises 1 cycle after the stop-bit centre sample. That is 2 (sync) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` (10· with parity) + 1 cycles after the line's falling edge reaches `gpio_pin_out[0]`, ±1 cycle of detection skew.
- Error pulses are exactly 1 cycle wide and coincide with the cycle `rx_valid` would have risen.
- Counter width: `$clog2(CLKS_PER_BIT)`. Bit counter 0–7. No wrap beyond the frame.

## Configuration
- `GPIO_UART_HOST_PARITY_EN` defined:
  - An even-parity bit is inserted after data bit 7 on TX; it equals the XOR of the 8 data bits.
  - RX expects and checks that bit; a mismatch pulses `rx_parity_err`.
  - Frames are 11 bits long.
- Undefined: 10-bit 8N1 frames, no parity logic, and `rx_parity_err` is constant 0.

## Test plan
- Loopback (`gpio_pin_out` = `gpio_pin_in`), `CLKS_PER_BIT`=16:
  - Send 8'hA5 → `rx_data`=8'hA5 with `rx_valid` high.
  - TX line low for exactly 16 cycles starting the cycle after acceptance.
  - `tx_ready` low for 160 cycles.
- Back-to-back: hold `tx_valid` with 8'h00 then 8'hFF.
  - No idle gap between frames.
  - Both bytes received, in order, with `rx_ready`=1.
- Overrun: receive 8'h11 with `rx_ready`=0, then 8'h22.
  - `rx_overrun` pulses once; `rx_data` stays 8'h11.
  - Asserting `rx_ready` then clears `rx_valid`.
- Framing/glitch:
  - A 4-cycle low glitch produces no output.
  - A frame for 8'h3C with stop forced to 0 gives an `rx_frame_err` pulse and `rx_valid` stays 0.
  - A following good 8'h3C is received.
- Reset mid-frame: assert `resetn`=0 during data bit 3 of a TX frame.
  - `gpio_pin_in`=8'h01 and `tx_ready`=1 immediately.
  - After release, a new byte 8'h5A transmits correctly.
- With `GPIO_UART_HOST_PARITY_EN`:
  - 8'h07 is sent with parity bit 1 and received cleanly.
  - An injected flipped parity bit pulses `rx_parity_err` and `rx_valid` stays 0.
